pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the five-stage core (IF/ID/EX/MB/WB).
- Watches hazards and redirects, then drives the stall, bubble and flush controls consumed by fetch, decode and execute.
- Its pipe_flush and data_hazard outputs feed the execute stage and CSR counters directly.
- Also sequences multi-cycle EX operations (iterative mul/div) and owns the stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_hazard_detect.sv | 22 ++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding and the
// width of the post-redirect flush counter.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PIPE_RUN     = 2'd0,
        PIPE_MC_BUSY = 2'd1,
        PIPE_FLUSH   = 2'd2
    } pipe_state_t;

    localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers of ID.
// Kept standalone so a store-data hazard check can reuse the same compare.
module hazard_detect (
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic [4:0] rd_addr,
    input  logic       mem_read,
    output logic       hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = rs1_used && (rs1_addr == rd_addr);
    assign rs2_match = rs2_used && (rs2_addr == rd_addr);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign hazard = mem_read && (rd_addr != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: drives stall/bubble/flush controls from hazards,
// redirects and the iterative mul/div unit, and keeps stall/flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id__rs1_addr,
    input  logic [4:0]       if_id__rs2_addr,
    input  logic             if_id__rs1_used,
    input  logic             if_id__rs2_used,
    input  logic [4:0]       id_ex__rd_addr,
    input  logic             id_ex__mem_read,
    input  logic             id_ex__multicycle,
    input  logic             mc_done,
    input  logic             mb_if__branch_taken,
    input  logic             mb_if__trap_taken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             id_ex_bubble,
    output logic             pipe_flush,
    output logic             data_hazard,
    output logic             mc_start,
    output logic             mc_abort,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    pipe_state_t            state;
    pipe_state_t            state_next;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic [FLUSH_CNT_W-1:0] flush_cnt_next;
    logic                   load_use;
    logic                   redirect;
    logic                   flush_event;

    hazard_detect u_hazard_detect (
        .rs1_addr (if_id__rs1_addr),
        .rs2_addr (if_id__rs2_addr),
        .rs1_used (if_id__rs1_used),
        .rs2_used (if_id__rs2_used),
        .rd_addr  (id_ex__rd_addr),
        .mem_read (id_ex__mem_read),
        .hazard   (load_use)
    );

    // Branches seen during FLUSH come from squashed instructions; traps still count
    assign redirect    = (state != PIPE_FLUSH) && (mb_if__branch_taken || mb_if__trap_taken);
    assign flush_event = redirect || ((state == PIPE_FLUSH) && mb_if__trap_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PIPE_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // The flush counter holds the FLUSH cycles still to go after the current one
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            PIPE_RUN, PIPE_MC_BUSY: begin
                if (redirect) begin
                    flush_cnt_next = FLUSH_RELOAD;
                    state_next     = (FLUSH_RELOAD == '0) ? PIPE_RUN : PIPE_FLUSH;
                end else if (state == PIPE_RUN && id_ex__multicycle) begin
                    state_next = PIPE_MC_BUSY;
                end else if (state == PIPE_MC_BUSY && mc_done) begin
                    state_next = PIPE_RUN;
                end
            end
            PIPE_FLUSH: begin
                if (mb_if__trap_taken) begin
                    flush_cnt_next = FLUSH_RELOAD;
                end else if (flush_cnt <= FLUSH_CNT_W'(1)) begin
                    flush_cnt_next = '0;
                    state_next     = PIPE_RUN;
                end else begin
                    flush_cnt_next = flush_cnt - FLUSH_CNT_W'(1);
                end
            end
            default: begin
                state_next     = PIPE_RUN;
                flush_cnt_next = '0;
            end
        endcase
    end

    // The multicycle start cycle also stalls so the op stays resident in EX
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_flush   = 1'b0;
        data_hazard  = 1'b0;
        mc_start     = 1'b0;
        mc_abort     = 1'b0;
        if (rst_n) begin
            case (state)
                PIPE_RUN: begin
                    if (redirect) begin
                        pipe_flush   = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (id_ex__multicycle) begin
                        mc_start    = 1'b1;
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_stall = 1'b1;
                    end else if (load_use) begin
                        data_hazard  = 1'b1;
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                PIPE_MC_BUSY: begin
                    if (redirect) begin
                        pipe_flush   = 1'b1;
                        id_ex_bubble = 1'b1;
                        mc_abort     = 1'b1;
                    end else if (!mc_done) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_stall = 1'b1;
                    end
                end
                PIPE_FLUSH: begin
                    pipe_flush   = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                default: begin
                    pipe_flush = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (pc_stall) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush_event) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: RUN-state vector table plus hand-written
// sequences for multicycle, redirect, trap and asynchronous reset cases.
module tb_pipe_ctrl;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic [4:0] rd;
        logic       mem_read;
        logic       multicycle;
        logic       mc_done;
        logic       branch;
        logic       trap;
    } stim_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic id_ex_bubble;
        logic pipe_flush;
        logic data_hazard;
        logic mc_start;
        logic mc_abort;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    localparam exp_t E_IDLE  = 8'b0000_0000;
    localparam exp_t E_LOAD  = 8'b1101_0100;
    localparam exp_t E_START = 8'b1110_0010;
    localparam exp_t E_BUSY  = 8'b1110_0000;
    localparam exp_t E_FLUSH = 8'b0001_1000;
    localparam exp_t E_ABORT = 8'b0001_1001;

    logic             clk;
    logic             rst_n;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic             rs1_used;
    logic             rs2_used;
    logic [4:0]       rd_addr;
    logic             mem_read;
    logic             multicycle;
    logic             mc_done;
    logic             branch_taken;
    logic             trap_taken;
    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             id_ex_bubble;
    logic             pipe_flush;
    logic             data_hazard;
    logic             mc_start;
    logic             mc_abort;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int               checks = 0;
    int               errors = 0;
    exp_t             exp_q[$];
    logic [CNT_W-1:0] stall_exp = '0;
    logic [CNT_W-1:0] flush_exp = '0;
    vec_t             table_v[8];

    pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .if_id__rs1_addr     (rs1_addr),
        .if_id__rs2_addr     (rs2_addr),
        .if_id__rs1_used     (rs1_used),
        .if_id__rs2_used     (rs2_used),
        .id_ex__rd_addr      (rd_addr),
        .id_ex__mem_read     (mem_read),
        .id_ex__multicycle   (multicycle),
        .mc_done             (mc_done),
        .mb_if__branch_taken (branch_taken),
        .mb_if__trap_taken   (trap_taken),
        .pc_stall            (pc_stall),
        .if_id_stall         (if_id_stall),
        .id_ex_stall         (id_ex_stall),
        .id_ex_bubble        (id_ex_bubble),
        .pipe_flush          (pipe_flush),
        .data_hazard         (data_hazard),
        .mc_start            (mc_start),
        .mc_abort            (mc_abort),
        .stall_count         (stall_count),
        .flush_count         (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t mk(input logic mcyc, input logic done,
                                 input logic br, input logic tr);
        stim_t s;
        s            = '0;
        s.multicycle = mcyc;
        s.mc_done    = done;
        s.branch     = br;
        s.trap       = tr;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rs1_addr     = s.rs1;
        rs2_addr     = s.rs2;
        rs1_used     = s.rs1_used;
        rs2_used     = s.rs2_used;
        rd_addr      = s.rd;
        mem_read     = s.mem_read;
        multicycle   = s.multicycle;
        mc_done      = s.mc_done;
        branch_taken = s.branch;
        trap_taken   = s.trap;
    endtask

    task automatic check_output(input string name);
        exp_t e;
        exp_t got;
        e   = exp_q.pop_front();
        got = {pc_stall, if_id_stall, id_ex_stall, id_ex_bubble,
               pipe_flush, data_hazard, mc_start, mc_abort};
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (pc,ifid,idex,bub,flush,haz,start,abort)",
                     name, got, e);
        end
    endtask

    task automatic check_value(input string name, input logic [CNT_W-1:0] got,
                               input logic [CNT_W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Drives one cycle of inputs, queues the expectation, checks mid-cycle,
    // then returns just after the next rising edge.
    task automatic apply_stimulus(input string name, input stim_t s, input exp_t e);
        drive(s);
        exp_q.push_back(e);
        if (e.pc_stall) stall_exp = stall_exp + 1'b1;
        @(negedge clk);
        check_output(name);
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string name);
        check_value({name, " stall_count"}, stall_count, stall_exp);
        check_value({name, " flush_count"}, flush_count, flush_exp);
    endtask

    initial begin
        stim_t s;

        table_v[0] = '{s: '0, e: E_IDLE};
        s = '0; s.rd = 5'd5; s.mem_read = 1'b1; s.rs2 = 5'd5; s.rs2_used = 1'b1;
        table_v[1] = '{s: s, e: E_LOAD};
        s = '0; s.rd = 5'd0; s.mem_read = 1'b1; s.rs2 = 5'd0; s.rs2_used = 1'b1;
        table_v[2] = '{s: s, e: E_IDLE};
        s = '0; s.rd = 5'd5; s.mem_read = 1'b1; s.rs2 = 5'd5; s.rs2_used = 1'b0;
        table_v[3] = '{s: s, e: E_IDLE};
        s = '0; s.rd = 5'd7; s.mem_read = 1'b0; s.rs1 = 5'd7; s.rs1_used = 1'b1;
        table_v[4] = '{s: s, e: E_IDLE};
        s = '0; s.rd = 5'd31; s.mem_read = 1'b1; s.rs1 = 5'd31; s.rs1_used = 1'b1; s.rs2 = 5'd3;
        table_v[5] = '{s: s, e: E_LOAD};
        s = '0; s.rd = 5'd9; s.mem_read = 1'b1; s.rs1 = 5'd8; s.rs1_used = 1'b1;
        s.rs2 = 5'd10; s.rs2_used = 1'b1;
        table_v[6] = '{s: s, e: E_IDLE};
        table_v[7] = '{s: mk(1'b0, 1'b1, 1'b0, 1'b0), e: E_IDLE};

        rst_n = 1'b0;
        drive('0);
        #12;
        exp_q.push_back(E_IDLE);
        check_output("reset outputs");
        check_counters("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus($sformatf("vector%0d", i), table_v[i].s, table_v[i].e);
        end
        check_counters("after vectors");

        apply_stimulus("mc start", mk(1'b1, 1'b0, 1'b0, 1'b0), E_START);
        for (int i = 0; i < 32; i++) begin
            apply_stimulus($sformatf("mc busy%0d", i), mk(1'b1, 1'b0, 1'b0, 1'b0), E_BUSY);
        end
        apply_stimulus("mc done", mk(1'b1, 1'b1, 1'b0, 1'b0), E_IDLE);
        apply_stimulus("mc after done", mk(1'b0, 1'b0, 1'b0, 1'b0), E_IDLE);
        check_counters("after multicycle");

        apply_stimulus("branch redirect", mk(1'b0, 1'b0, 1'b1, 1'b0), E_FLUSH);
        flush_exp = flush_exp + 1'b1;
        apply_stimulus("branch in flush", mk(1'b0, 1'b0, 1'b1, 1'b0), E_FLUSH);
        apply_stimulus("run after branch", mk(1'b0, 1'b0, 1'b0, 1'b0), E_IDLE);
        check_counters("after branch");

        apply_stimulus("trap mc start", mk(1'b1, 1'b0, 1'b0, 1'b0), E_START);
        apply_stimulus("trap mc busy", mk(1'b1, 1'b0, 1'b0, 1'b0), E_BUSY);
        apply_stimulus("trap in mc", mk(1'b1, 1'b0, 1'b0, 1'b1), E_ABORT);
        flush_exp = flush_exp + 1'b1;
        apply_stimulus("flush after abort", mk(1'b0, 1'b1, 1'b0, 1'b0), E_FLUSH);
        apply_stimulus("late mc_done", mk(1'b0, 1'b1, 1'b0, 1'b0), E_IDLE);
        check_counters("after trap in mc");

        apply_stimulus("redirect before trap", mk(1'b0, 1'b0, 1'b1, 1'b0), E_FLUSH);
        flush_exp = flush_exp + 1'b1;
        apply_stimulus("trap in flush", mk(1'b0, 1'b0, 1'b0, 1'b1), E_FLUSH);
        flush_exp = flush_exp + 1'b1;
        apply_stimulus("extended flush", mk(1'b0, 1'b0, 1'b0, 1'b0), E_FLUSH);
        apply_stimulus("run after trap", mk(1'b0, 1'b0, 1'b0, 1'b0), E_IDLE);
        check_counters("after trap in flush");

        apply_stimulus("pre-reset mc start", mk(1'b1, 1'b0, 1'b0, 1'b0), E_START);
        apply_stimulus("pre-reset mc busy", mk(1'b1, 1'b0, 1'b0, 1'b0), E_BUSY);
        drive(mk(1'b1, 1'b0, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        stall_exp = '0;
        flush_exp = '0;
        exp_q.push_back(E_IDLE);
        check_output("async reset outputs");
        check_counters("async reset");
        drive('0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus("run after reset", mk(1'b0, 1'b0, 1'b0, 1'b0), E_IDLE);
        apply_stimulus("branch after reset", mk(1'b0, 1'b0, 1'b1, 1'b0), E_FLUSH);
        flush_exp = flush_exp + 1'b1;
        apply_stimulus("flush after reset", mk(1'b0, 1'b0, 1'b0, 1'b0), E_FLUSH);
        check_counters("after reset release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
